// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles the signals between the two MEM-stage lanes, the single-ported
//   data memory and the dmem_port_arbiter.
//
//   Lane request side   : re1/we1/addr1/wdata1, re2/we2/addr2/wdata2
//   Memory port side    : mem_re/mem_we/mem_addr/mem_wdata, mem_rdata
//   Pipeline feedback   : stall, rdata1/rdata2 (WB load data), conflict_cnt
//
//   Modports:
//     slave  - the arbiter (consumes lane requests and memory read data)
//     master - the surrounding pipeline/memory (produces them)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              re1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              re2;
  logic              we2;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata2;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  re1, we1, addr1, wdata1,
    input  re2, we2, addr2, wdata2,
    input  mem_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    output stall, rdata1, rdata2, conflict_cnt
  );

  modport master (
    output re1, we1, addr1, wdata1,
    output re2, we2, addr2, wdata2,
    output mem_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    input  stall, rdata1, rdata2, conflict_cnt
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one synchronous single-ported data memory between the two MEM-stage
//   lanes of a dual-issue pipeline. When both lanes access memory in the same
//   cycle, lane 1 (older) goes first while the front of the pipeline is
//   stalled for one cycle, then the captured lane 2 request is issued. Load
//   data is realigned so that both lanes see their result in their WB cycle.
//
//   Ports:
//     clk  - pipeline clock
//     rst  - asynchronous active-low reset
//     bus  - dmem_port_arbiter_if.slave: lane requests, memory port,
//            stall, per-lane WB load data and the saturating conflict count
//
//   Optional feature macro: DMEM_ARB_COALESCE_EN
//     When defined, two plain reads of the same address in the same cycle are
//     merged into one access (no stall, not counted as a conflict).
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              h_re_q, h_re_d;
  logic              h_we_q, h_we_d;
  logic [ADDR_W-1:0] h_addr_q, h_addr_d;
  logic [DATA_W-1:0] h_wdata_q, h_wdata_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic              split_q, split_d;
  logic              wb_sel_q, wb_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              act1, act2, coalesce, conflict;
  logic              port_re, port_we, stall;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign act1 = bus.re1 | bus.we1;
  assign act2 = bus.re2 | bus.we2;

`ifdef DMEM_ARB_COALESCE_EN
  assign coalesce = bus.re1 & bus.re2 & ~bus.we1 & ~bus.we2 &
                    (bus.addr1 == bus.addr2);
`else
  assign coalesce = 1'b0;
`endif

  assign conflict = act1 & act2 & ~coalesce;

  always_comb begin
    state_d    = state_q;
    h_re_d     = h_re_q;
    h_we_d     = h_we_q;
    h_addr_d   = h_addr_q;
    h_wdata_d  = h_wdata_q;
    hold1_d    = hold1_q;
    split_d    = 1'b0;
    wb_sel_d   = split_q;
    cnt_d      = cnt_q;
    port_re    = 1'b0;
    port_we    = 1'b0;
    port_addr  = '0;
    port_wdata = '0;
    stall      = 1'b0;

    case (state_q)
      IDLE: begin
        // Lane 1 is older, so it owns the port whenever it is active.
        if (act1) begin
          port_re    = bus.re1;
          port_we    = bus.we1;
          port_addr  = bus.addr1;
          port_wdata = bus.wdata1;
        end else if (act2) begin
          port_re    = bus.re2;
          port_we    = bus.we2;
          port_addr  = bus.addr2;
          port_wdata = bus.wdata2;
        end
        if (conflict) begin
          stall     = 1'b1;
          h_re_d    = bus.re2;
          h_we_d    = bus.we2;
          h_addr_d  = bus.addr2;
          h_wdata_d = bus.wdata2;
          split_d   = 1'b1;
          cnt_d     = sat_inc(cnt_q);
          state_d   = SECOND;
        end
      end
      SECOND: begin
        // Live lane 2 inputs are still the stalled instruction; use the copy.
        port_re    = h_re_q;
        port_we    = h_we_q;
        port_addr  = h_addr_q;
        port_wdata = h_wdata_q;
        // mem_rdata now carries lane 1's load; park it until WB.
        hold1_d    = bus.mem_rdata;
        state_d    = IDLE;
      end
      default: ;
    endcase

    // Keep the memory port quiet for the whole time reset is held.
    if (!rst) begin
      port_re    = 1'b0;
      port_we    = 1'b0;
      port_addr  = '0;
      port_wdata = '0;
      stall      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      h_re_q   <= 1'b0;
      h_we_q   <= 1'b0;
      hold1_q  <= '0;
      split_q  <= 1'b0;
      wb_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_re_q   <= h_re_d;
      h_we_q   <= h_we_d;
      hold1_q  <= hold1_d;
      split_q  <= split_d;
      wb_sel_q <= wb_sel_d;
      cnt_q    <= cnt_d;
    end
  end

  // Captured address/data are only consumed when h_re_q/h_we_q say so.
  always_ff @(posedge clk) begin
    h_addr_q  <= h_addr_d;
    h_wdata_q <= h_wdata_d;
  end

  assign bus.mem_re       = port_re;
  assign bus.mem_we       = port_we;
  assign bus.mem_addr     = port_addr;
  assign bus.mem_wdata    = port_wdata;
  assign bus.stall        = stall;
  assign bus.rdata1       = wb_sel_q ? hold1_q : bus.mem_rdata;
  assign bus.rdata2       = bus.mem_rdata;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-ported memory with 1-cycle read latency plus a preload path.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    bit              re;
    bit              we;
    bit [ADDR_W-1:0] addr;
    bit [DATA_W-1:0] wdata;
  } req_t;

  typedef struct {
    int              cyc;
    bit              v1;
    bit [DATA_W-1:0] d1;
    bit              v2;
    bit [DATA_W-1:0] d2;
  } wb_t;

  bit [DATA_W-1:0] refmem [0:(1<<ADDR_W)-1];
  req_t pend[$];
  req_t lst[$];
  wb_t  wbq[$];
  int   mcnt = 0;

  always @(negedge clk) begin
    req_t e, l1, l2;
    wb_t  w;
    bit   est, coal;
    if (pl_en) refmem[pl_addr] = pl_data;
    if (!rst) begin
      chk("rst_mem_re", bus.mem_re, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_cnt", bus.conflict_cnt, 0);
      pend.delete();
      wbq.delete();
      mcnt = 0;
    end else begin
      while (wbq.size() > 0 && wbq[0].cyc <= cyc) begin
        w = wbq.pop_front();
        if (w.v1) chk("m_rdata1", bus.rdata1, w.d1);
        if (w.v2) chk("m_rdata2", bus.rdata2, w.d2);
      end
      e   = '{re: 1'b0, we: 1'b0, addr: '0, wdata: '0};
      est = 1'b0;
      if (pend.size() > 0) begin
        e = pend.pop_front();
      end else begin
        l1 = '{re: bus.re1, we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
        l2 = '{re: bus.re2, we: bus.we2, addr: bus.addr2, wdata: bus.wdata2};
        coal = 1'b0;
`ifdef DMEM_ARB_COALESCE_EN
        coal = l1.re && l2.re && !l1.we && !l2.we && (l1.addr == l2.addr);
`endif
        if (l1.re || l1.we) lst.push_back(l1);
        if ((l2.re || l2.we) && !coal) lst.push_back(l2);
        if (lst.size() > 0) e = lst.pop_front();
        if (lst.size() > 0) begin
          est = 1'b1;
          pend.push_back(lst.pop_front());
        end
        // Program order: lane 1 observes memory before lane 2.
        if (l1.re || l1.we || l2.re || l2.we) begin
          w.cyc = cyc + (est ? 2 : 1);
          w.v1  = l1.re;
          w.d1  = refmem[l1.addr];
          if (l1.we) refmem[l1.addr] = l1.wdata;
          w.v2  = l2.re;
          w.d2  = refmem[l2.addr];
          if (l2.we) refmem[l2.addr] = l2.wdata;
          if (l1.re || l2.re) wbq.push_back(w);
        end
      end
      chk("m_mem_re", bus.mem_re, e.re);
      chk("m_mem_we", bus.mem_we, e.we);
      chk("m_mem_addr", bus.mem_addr, e.addr);
      chk("m_mem_wdata", bus.mem_wdata, e.wdata);
      chk("m_stall", bus.stall, est);
      chk("m_cnt", bus.conflict_cnt, mcnt);
      if (est && mcnt < CNT_MAX) mcnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setl(input bit r1, input bit w1, input int a1, input logic [DATA_W-1:0] d1,
                      input bit r2, input bit w2, input int a2, input logic [DATA_W-1:0] d2);
    bus.re1 = r1; bus.we1 = w1; bus.addr1 = ADDR_W'(a1); bus.wdata1 = d1;
    bus.re2 = r2; bus.we2 = w2; bus.addr2 = ADDR_W'(a2); bus.wdata2 = d2;
  endtask

  task automatic idle();
    setl(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic preload(input int a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = ADDR_W'(a); pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    idle();
    rst = 1'b0;
    tick();
    preload(5, 32'hAAAA0001);
    preload(3, 32'h11);
    preload(7, 32'h22);
    preload(9, 32'h0);
    preload(4, 32'h44);
    preload(12, 32'h12345678);
    @(negedge clk);
    chk("reset_cnt", bus.conflict_cnt, 0);
    chk("reset_stall", bus.stall, 0);
    tick();
    rst = 1'b1;

    // single lane 1 read
    setl(1, 0, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_stall", bus.stall, 0);
    chk("single_addr", bus.mem_addr, 5);
    tick(); idle();
    @(negedge clk);
    chk("single_rdata1", bus.rdata1, 32'hAAAA0001);
    chk("single_cnt", bus.conflict_cnt, 0);
    tick();

    // single lane 2 read
    setl(0, 0, 0, 0, 1, 0, 7, 0);
    @(negedge clk);
    chk("lane2_stall", bus.stall, 0);
    chk("lane2_addr", bus.mem_addr, 7);
    tick(); idle();
    @(negedge clk);
    chk("lane2_rdata2", bus.rdata2, 32'h22);
    tick();

    // dual read: serialized, one stall
    setl(1, 0, 3, 0, 1, 0, 7, 0);
    @(negedge clk);
    chk("dual_stall_t", bus.stall, 1);
    chk("dual_addr_t", bus.mem_addr, 3);
    tick();
    @(negedge clk);
    chk("dual_stall_t1", bus.stall, 0);
    chk("dual_addr_t1", bus.mem_addr, 7);
    chk("dual_cnt", bus.conflict_cnt, 1);
    tick(); idle();
    @(negedge clk);
    chk("dual_rdata1", bus.rdata1, 32'h11);
    chk("dual_rdata2", bus.rdata2, 32'h22);
    chk("dual_stall_t2", bus.stall, 0);
    tick();

    // lane 1 write then lane 2 read of same address
    setl(0, 1, 9, 32'hDEAD, 1, 0, 9, 0);
    @(negedge clk);
    chk("raw_we_first", bus.mem_we, 1);
    tick();
    @(negedge clk);
    chk("raw_re_second", bus.mem_re, 1);
    tick(); idle();
    @(negedge clk);
    chk("raw_rdata2", bus.rdata2, 32'hDEAD);
    tick();

    // both lanes write the same address: lane 2 wins
    setl(0, 1, 9, 32'h1, 0, 1, 9, 32'h2);
    tick(); tick(); idle();
    @(negedge clk);
    chk("waw_mem9", mem[9], 32'h2);
    tick();

    // lane 1 read, lane 2 write same address: lane 1 sees old value
    setl(1, 0, 9, 0, 0, 1, 9, 32'h3);
    tick(); tick(); idle();
    @(negedge clk);
    chk("war_rdata1", bus.rdata1, 32'h2);
    chk("war_mem9", mem[9], 32'h3);
    chk("war_cnt_sat", bus.conflict_cnt, 3);
    tick();

    // same-address dual read
    setl(1, 0, 4, 0, 1, 0, 4, 0);
`ifdef DMEM_ARB_COALESCE_EN
    @(negedge clk);
    chk("coal_stall", bus.stall, 0);
    tick(); idle();
`else
    @(negedge clk);
    chk("coal_stall", bus.stall, 1);
    tick();
    tick(); idle();
`endif
    @(negedge clk);
    chk("coal_rdata1", bus.rdata1, 32'h44);
    chk("coal_rdata2", bus.rdata2, 32'h44);
    tick();

    // reset asserted while in the second (lane 2) cycle
    setl(1, 0, 3, 0, 1, 0, 7, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_stall", bus.stall, 0);
    chk("rmid_mem_re", bus.mem_re, 0);
    chk("rmid_cnt", bus.conflict_cnt, 0);
    tick(); idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rpost_mem_re", bus.mem_re, 0);
    chk("rpost_stall", bus.stall, 0);
    chk("rpost_cnt", bus.conflict_cnt, 0);
    tick();

    // back-to-back conflicts, counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      setl(1, 0, 12, 0, 1, 0, 3, 0);
      @(negedge clk);
      chk("sat_stall", bus.stall, 1);
      tick();
      @(negedge clk);
      chk("sat_cnt", bus.conflict_cnt, sat_exp[i]);
      tick();
    end
    idle();
    @(negedge clk);
    chk("sat_rdata1", bus.rdata1, 32'h12345678);
    chk("sat_rdata2", bus.rdata2, 32'h11);
    tick();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbiter between the two MEM-stage lanes of the dual-issue pipeline and the single-ported synchronous data memory. When both lanes access memory in the same cycle, it serializes them in program order: lane 1 first, because it is older. During the extra cycle it stalls the front of the pipeline. It also realigns read data so each lane sees its load result in its WB cycle.

## Interface
Parameters:
- ADDR_W, 10, data-memory word-address width
- DATA_W, 32, data width
- CNT_W, 16, width of the conflict counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- re1, we1  in  1 each  lane 1 MEM-stage read / write enable (already squashed for bubbles)
- addr1  in  ADDR_W  lane 1 word address
- wdata1  in  DATA_W  lane 1 store data
- re2, we2, addr2, wdata2  in  1/1/ADDR_W/DATA_W  same signals for lane 2
- mem_re, mem_we  out  1 each  memory port enables
- mem_addr  out  ADDR_W  memory port address
- mem_wdata  out  DATA_W  memory port write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM for one cycle
- rdata1, rdata2  out  DATA_W  per-lane load data for the WB stage
- conflict_cnt  out  CNT_W  saturating count of serialized pairs

## Operation
- Lane N is active when reN or weN is asserted. `conflict` = both lanes active, excluding the coalesced case (see Configuration).
- FSM has two states:
  - IDLE:
    - Port driven by whichever single lane is active. Lane 1 has priority; there is no conflict if only one lane is active.
    - On conflict: drive lane 1, assert `stall` combinationally, capture lane 2's re/we/addr/wdata into holding registers, go to SECOND.
  - SECOND:
    - Drive the port from the captured lane 2 request. `stall`=0. Return to IDLE unconditionally.
    - Live lane 2 inputs are ignored in this state.
- Program-order semantics follow from lane 1 going first:
  - Lane 1 write and lane 2 read to the same address: lane 2 reads the new data.
  - Lane 1 read and lane 2 write to the same address: lane 1 reads the old data.
  - Both lanes write the same address: lane 2's value remains.
- Read data routing:
  - `split` register is set on the IDLE->SECOND edge and cleared on the next edge.
  - When the port access in IDLE is for lane 1 under conflict, `mem_rdata` is captured into `hold1` during SECOND.
  - `rdata1` = `hold1` in the cycle after SECOND, otherwise `mem_rdata`.
  - `rdata2` = `mem_rdata`.
- `conflict_cnt` increments on each IDLE->SECOND transition and saturates at all-ones.
- Port outputs are 0 when no lane is active.
- Reset (asynchronous, any state, including mid-SECOND):
  - State returns to IDLE; the captured request is dropped.
  - `stall`=0; `hold1`, `split` and `conflict_cnt` = 0.
  - All mem_* outputs = 0; `rdata1`/`rdata2` follow `mem_rdata`.

## Timing
- No conflict: access in cycle T, load data on `rdata1`/`rdata2` in T+1, which is the WB cycle. No added latency.
- Conflict in T:
  - T: lane 1 accessed, `stall`=1.
  - T+1: lane 2 accessed, `stall`=0, pipeline advances at the end of T+1.
  - T+2: WB, with `rdata1`=`hold1` and `rdata2`=`mem_rdata`.
- Penalty is exactly one cycle per conflicting pair. `stall` is never asserted in two consecutive cycles.
- All port outputs are combinational from state and inputs. Memory latency is fixed at one cycle.

## Configuration
- DMEM_ARB_COALESCE_EN:
  - Defined: re1 & re2 & !we1 & !we2 & (addr1==addr2) is not a conflict. A single access is issued using lane 1's address, and both `rdata1` and `rdata2` = `mem_rdata` in T+1. No stall, no count.
  - Undefined: this case serializes like any other conflict.

## Test plan
- Single lane: re1, addr1=5, memory[5]=0xAAAA0001 -> `stall`=0; `rdata1`=0xAAAA0001 next cycle; `conflict_cnt`=0.
- Dual read: re1@3, re2@7 with mem[3]=0x11 and mem[7]=0x22 -> `stall`=1 for exactly one cycle; port addresses 3 then 7; WB sees `rdata1`=0x11, `rdata2`=0x22; `conflict_cnt`=1.
- Ordering: we1@9 with 0xDEAD, plus re2@9 -> lane 2 returns 0xDEAD. Then we1@9 with 0x1, plus we2@9 with 0x2 -> mem[9]=0x2.
- Coalesce: re1=re2@4, mem[4]=0x44. With DMEM_ARB_COALESCE_EN: no stall, both lanes read 0x44. Without it: one stall cycle, both lanes still read 0x44.
- Reset mid-SECOND: assert rst low during SECOND -> state IDLE, `stall`=0, no lane 2 access issued, `conflict_cnt`=0.
- Saturation: CNT_W=2 with 5 back-to-back conflicts -> `conflict_cnt` reads 1, 2, 3, 3, 3.
